// File: rtl/vp_cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : vp_cfg_sequencer_if
// Purpose  : Configuration request bus between the bus-side register block
//            (master) and the frame-synchronous configuration sequencer
//            (slave).
// Signals  : cfg_req        level request, held until cfg_ack
//            cfg_ack        one-cycle pulse, request applied or rejected
//            cfg_err        one-cycle pulse with cfg_ack on rejection
//            new_cr         requested VP_CR
//            new_start      requested start  [10:0] X, [26:16] Y
//            new_end        requested end    [10:0] X, [26:16] Y
//            new_scaler     requested output resolution [10:0] X, [26:16] Y
//            new_threshold  requested thresholds
// Revision : 1.0 - initial release
// ============================================================================
interface vp_cfg_sequencer_if;
  logic        cfg_req;
  logic        cfg_ack;
  logic        cfg_err;
  logic [31:0] new_cr;
  logic [31:0] new_start;
  logic [31:0] new_end;
  logic [31:0] new_scaler;
  logic [31:0] new_threshold;

  modport master (
    output cfg_req, new_cr, new_start, new_end, new_scaler, new_threshold,
    input  cfg_ack, cfg_err
  );

  modport slave (
    input  cfg_req, new_cr, new_start, new_end, new_scaler, new_threshold,
    output cfg_ack, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/vp_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vp_cfg_sequencer
// Purpose  : Frame-synchronous configuration controller for the video
//            pipeline. Captures a configuration set over a req/ack handshake,
//            validates it, applies it on the next vertical-sync rising edge
//            and then mutes the output for FLUSH_FRAMES frames.
// Ports    : clk            pixel clock (vi_clk domain)
//            rst_n          synchronous, active-low reset
//            vs_in          vertical sync, active high
//            cfg            request bus (slave side of vp_cfg_sequencer_if)
//            act_*          active configuration driven to the pipeline
//            mute           high = downstream forces de low
//            busy           high whenever a transaction is in progress
//            frame_cnt      count of vs rising edges (wraps)
//            timeout_flag   sticky WAIT_VS timeout indicator (optional)
// Options  : VP_CFG_TIMEOUT_EN - when defined, WAIT_VS gives up after
//            TIMEOUT_CYCLES cycles, applies anyway and sets timeout_flag.
// Revision : 1.0 - initial release
// ============================================================================
module vp_cfg_sequencer #(
  parameter int          H_DISP         = 1280,
  parameter int          V_DISP         = 720,
  parameter int          FLUSH_FRAMES   = 2
`ifdef VP_CFG_TIMEOUT_EN
  ,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vs_in,
  vp_cfg_sequencer_if.slave        cfg,
  output logic [31:0]              act_cr,
  output logic [31:0]              act_start,
  output logic [31:0]              act_end,
  output logic [31:0]              act_scaler,
  output logic [31:0]              act_threshold,
  output logic                     mute,
  output logic                     busy,
  output logic [15:0]              frame_cnt
`ifdef VP_CFG_TIMEOUT_EN
  ,
  output logic                     timeout_flag
`endif
);

  localparam logic [10:0] H_MAX      = 11'(H_DISP);
  localparam logic [10:0] V_MAX      = 11'(V_DISP);
  localparam logic [31:0] END_RST    = {5'b0, V_MAX, 5'b0, H_MAX};
  localparam logic [31:0] THR_RST    = 32'h0000_8040;
  localparam logic [3:0]  FLUSH_INIT = 4'(FLUSH_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_WAIT_VS = 3'd2,
    S_FLUSH   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      state, state_nxt;

  logic        vs_d;
  logic        vs_rise;
  logic        cfg_ok;
  logic        apply_trig;

  logic        capture, reject, apply, flush_step;

  logic [31:0] pend_cr, pend_start, pend_end, pend_scaler, pend_threshold;
  logic [31:0] act_cr_q, act_start_q, act_end_q, act_scaler_q, act_threshold_q;
  logic        ack_q, err_q, mute_q;
  logic [3:0]  flush_cnt;
  logic [15:0] frame_cnt_q;

  assign vs_rise = vs_in & ~vs_d;

  // Validation works on the captured copy only, so later new_* changes
  // cannot influence the decision.
  assign cfg_ok = (pend_end[10:0]     >  pend_start[10:0])  &&
                  (pend_end[26:16]    >  pend_start[26:16]) &&
                  (pend_scaler[10:0]  != 11'd0)             &&
                  (pend_scaler[26:16] != 11'd0)             &&
                  (pend_scaler[10:0]  <= H_MAX)             &&
                  (pend_scaler[26:16] <= V_MAX);

`ifdef VP_CFG_TIMEOUT_EN
  logic [23:0] to_cnt;
  logic        to_hit;
  logic        timeout_q;

  assign to_hit     = (state == S_WAIT_VS) && (to_cnt == (TIMEOUT_CYCLES - 24'd1));
  assign apply_trig = vs_rise | to_hit;

  // Counter is held at zero outside WAIT_VS, so it starts fresh on entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt    <= 24'd0;
      timeout_q <= 1'b0;
    end else begin
      if (state != S_WAIT_VS) begin
        to_cnt <= 24'd0;
      end else begin
        to_cnt <= to_cnt + 24'd1;
      end
      if (to_hit && !vs_rise) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_flag = timeout_q;
`else
  assign apply_trig = vs_rise;
`endif

  // Next-state and control strobes. A vs_rise during CHECK is deliberately
  // not looked at: the switch waits for the following rising edge.
  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    reject     = 1'b0;
    apply      = 1'b0;
    flush_step = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg.cfg_req) begin
          capture   = 1'b1;
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cfg_ok) begin
          state_nxt = S_WAIT_VS;
        end else begin
          reject    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_WAIT_VS: begin
        if (apply_trig) begin
          apply     = 1'b1;
          state_nxt = (FLUSH_INIT != 4'd0) ? S_FLUSH : S_DONE;
        end
      end
      S_FLUSH: begin
        if (vs_rise) begin
          flush_step = 1'b1;
          if (flush_cnt == 4'd1) begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Waiting for req to fall stops a held req from re-triggering.
        if (!cfg.cfg_req) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      vs_d            <= 1'b0;
      frame_cnt_q     <= 16'd0;
      ack_q           <= 1'b0;
      err_q           <= 1'b0;
      mute_q          <= 1'b0;
      flush_cnt       <= 4'd0;
      pend_cr         <= 32'd0;
      pend_start      <= 32'd0;
      pend_end        <= END_RST;
      pend_scaler     <= END_RST;
      pend_threshold  <= THR_RST;
      act_cr_q        <= 32'd0;
      act_start_q     <= 32'd0;
      act_end_q       <= END_RST;
      act_scaler_q    <= END_RST;
      act_threshold_q <= THR_RST;
    end else begin
      state <= state_nxt;
      vs_d  <= vs_in;
      if (vs_rise) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      ack_q <= reject | apply;
      err_q <= reject;
      if (capture) begin
        pend_cr        <= cfg.new_cr;
        pend_start     <= cfg.new_start;
        pend_end       <= cfg.new_end;
        pend_scaler    <= cfg.new_scaler;
        pend_threshold <= cfg.new_threshold;
      end
      if (apply) begin
        act_cr_q        <= pend_cr;
        act_start_q     <= pend_start;
        act_end_q       <= pend_end;
        act_scaler_q    <= pend_scaler;
        act_threshold_q <= pend_threshold;
        flush_cnt       <= FLUSH_INIT;
        mute_q          <= (FLUSH_INIT != 4'd0);
      end
      if (flush_step) begin
        flush_cnt <= flush_cnt - 4'd1;
        if (flush_cnt == 4'd1) begin
          mute_q <= 1'b0;
        end
      end
    end
  end

  assign cfg.cfg_ack   = ack_q;
  assign cfg.cfg_err   = err_q;
  assign act_cr        = act_cr_q;
  assign act_start     = act_start_q;
  assign act_end       = act_end_q;
  assign act_scaler    = act_scaler_q;
  assign act_threshold = act_threshold_q;
  assign mute          = mute_q;
  assign busy          = (state != S_IDLE);
  assign frame_cnt     = frame_cnt_q;

endmodule
`default_nettype wire

// File: doc/vp_cfg_sequencer.md
Name: vp_cfg_sequencer

Overview:
- Frame-synchronous configuration controller for the video-processing pipeline (cutter/filter/scaler/rgb2ycbcr/edger/binarizer/filler).
- Accepts a configuration set from the bus-side register block over a req/ack handshake and validates it. Applies it only on a vertical-sync rising edge, so no frame is processed with mixed settings.
- After each switch, mutes the output for a programmable number of frames so the pipeline can flush.
- Sits in the vi_clk domain between the AHB register file and the pipeline's VP_* configuration inputs.

Parameters:
- H_DISP, 1280, maximum horizontal resolution; also the reset value for end X and output X resolution.
- V_DISP, 720, maximum vertical resolution; also the reset value for end Y and output Y resolution.
- FLUSH_FRAMES, 2, number of vs rising edges output stays muted after a config switch (0 = no mute; legal range 0..15).
- TIMEOUT_CYCLES, 24'd2000000, WAIT_VS timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  pixel clock (vi_clk domain)
- rst_n  in  1  reset
- vs_in  in  1  input vertical sync, active high, synchronous to clk
- cfg_req  in  1  level request: pending config valid; held until cfg_ack
- cfg_ack  out  1  one-cycle pulse: request applied or rejected
- cfg_err  out  1  one-cycle pulse coincident with cfg_ack when config is rejected
- new_cr  in  32  requested VP_CR
- new_start  in  32  requested start: [10:0] X, [26:16] Y
- new_end  in  32  requested end: [10:0] X, [26:16] Y
- new_scaler  in  32  requested output resolution: [10:0] X, [26:16] Y
- new_threshold  in  32  requested thresholds
- act_cr, act_start, act_end, act_scaler, act_threshold  out  32 each  active config driven to the pipeline
- mute  out  1  high = downstream must force de low
- busy  out  1  high in any state other than IDLE
- frame_cnt  out  16  count of vs rising edges
- timeout_flag  out  1  sticky; present only with VP_CFG_TIMEOUT_EN

Behaviour:
- Reset: rst_n is synchronous and active-low. All flops are initialised on the clk edge where rst_n=0. An asserted reset mid-operation aborts any transaction: no ack is issued, and the active config returns to its reset values.
- Reset values of outputs:
  - act_cr=0
  - act_start=0
  - act_end={5'b0,V_DISP[10:0],5'b0,H_DISP[10:0]}
  - act_scaler equal to act_end
  - act_threshold=32'h0000_8040
  - mute=0, busy=0, cfg_ack=0, cfg_err=0, frame_cnt=0, timeout_flag=0
- Edge detect: vs_d is vs_in registered; vs_rise = vs_in & ~vs_d. frame_cnt increments on every vs_rise in every state and wraps 0xFFFF->0.
- State machine (IDLE, CHECK, WAIT_VS, FLUSH, DONE):
  - IDLE: if cfg_req=1 at edge T, capture all new_* into pending registers at T and move to CHECK. busy=1 from T+1.
  - CHECK (1 cycle): the config is valid iff all of the following hold:
    - end X > start X and end Y > start Y (unsigned, 11-bit)
    - scaler X != 0 and scaler Y != 0
    - scaler X <= H_DISP and scaler Y <= V_DISP
  - CHECK, invalid: cfg_ack=1 and cfg_err=1 for one cycle, active config unchanged, go to DONE.
  - CHECK, valid: go to WAIT_VS.
  - WAIT_VS: on vs_rise at edge E, at E+1 copy pending to act_*, pulse cfg_ack and load flush counter with FLUSH_FRAMES.
    - If FLUSH_FRAMES>0: mute=1 from E+1, go to FLUSH.
    - Otherwise go to DONE.
  - Simultaneous vs_rise in the CHECK cycle is not honoured; the switch waits for the next vs_rise.
  - FLUSH: each vs_rise decrements the counter. At the edge where it reaches 0, mute returns to 0 on the next cycle and the state goes to DONE.
  - DONE: wait for cfg_req=0, then go to IDLE. A req still high after ack never starts a second transaction.
- cfg_req dropping before ack (protocol violation) is ignored: the transaction completes.
- new_* changes after capture have no effect.
- act_* change only in the cycle after a WAIT_VS vs_rise; they are stable for all other cycles.

Optional Feature:
- Macro VP_CFG_TIMEOUT_EN.
- Defined: a 24-bit counter runs in WAIT_VS, cleared on entry. When it reaches TIMEOUT_CYCLES-1 without a vs_rise, apply the config exactly as on vs_rise and set timeout_flag. timeout_flag is sticky until reset.
- Not defined: WAIT_VS waits indefinitely; timeout_flag port and counter are absent.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles -> act_end=0x02D0_0500, act_threshold=0x0000_8040, mute=0, busy=0, frame_cnt=0.
2. Valid switch: FLUSH_FRAMES=2; req with start=0x0048_0080, end=0x0198_0300, scaler=0x02D0_0500; vs_rise 50 cycles later -> act_* update and cfg_ack on the cycle after vs_rise; mute high for exactly 2 further vs_rise edges; busy low after req drops.
3. Invalid config: end X=0x080 equal to start X=0x080 -> cfg_ack and cfg_err pulse together 2 cycles after req is sampled; act_* unchanged; no mute.
4. Req held high 100 cycles after ack -> no second ack; then drop req, re-raise -> new transaction accepted.
5. vs_rise in the same cycle as CHECK -> no apply on that edge; apply on the next vs_rise. frame_cnt preset near 0xFFFF with 2 edges -> wraps to 0x0001.
6. With VP_CFG_TIMEOUT_EN, TIMEOUT_CYCLES=100, vs held low -> apply and cfg_ack after 100 WAIT_VS cycles, timeout_flag=1 until reset.
